ahb_apb_bridge_multi: RTL

AHB-Lite slave to APB master bridge that fans out to NUM_SLAVES APB peripherals through a per-slave PSEL decode. It supports APB wait states (PREADY), slave errors (PSLVERR), decode errors and an optional wait-state timeout. Any of these error conditions produces a two-cycle AHB ERROR response. The block sits between the AHB interconnect and the peripheral subsystem. It is single clock domain; PCLK is HCLK.

---
 rtl/ahb_apb_bridge_multi.sv | 93 +++++++++
 1 files changed

// File: rtl/ahb_apb_bridge_multi.sv
// ahb_apb_bridge_multi: AHB-Lite slave to multi-slave APB master with decode, slave-error and timeout ERROR responses.
module ahb_apb_bridge_multi #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_SLAVES      = 4,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT         = 0
) (
    input  logic                             HCLK,
    input  logic                             HRESET,
    input  logic                             HSEL,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    input  logic                             HREADY_IN,
    input  logic [DATA_WIDTH-1:0]            HWDATA,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic                             HRESP,
    output logic                             HREADY_OUT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);
    localparam int IDX_W = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, WLATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

    state_t state, state_n;
    logic [IDX_W-1:0] idx_q, idx_in, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic accept, dec_err, sel_ready, sel_err, timeout, unused;

    assign unused    = HTRANS[0];
    assign idx_in    = NUM_SLAVES > 1 ? HADDR[SLAVE_ADDR_BITS +: IDX_W] : '0;
    assign dec_err   = int'(idx_in) >= NUM_SLAVES;
    assign accept    = HSEL && HTRANS[1] && HREADY_IN && (state == IDLE || state == ERR2);
    assign idx_n     = accept ? idx_in : idx_q;
    assign sel_ready = PREADY[idx_q];
    assign sel_err   = PSLVERR[idx_q];
    assign cnt_n     = cnt + 1'b1;
    assign timeout   = (TIMEOUT != 0) && (cnt_n == CNT_W'(TIMEOUT));

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ERR2: state_n = accept ? (dec_err ? ERR1 : HWRITE ? WLATCH : SETUP) : IDLE;
            WLATCH:     state_n = SETUP;
            SETUP:      state_n = ACCESS;
            ACCESS:     state_n = sel_ready ? (sel_err ? ERR1 : IDLE) : timeout ? ERR1 : ACCESS;
            ERR1:       state_n = ERR2;
            default:    state_n = IDLE;
        endcase
    end

    // Bus outputs are registered straight from the next state so they line up with it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= IDLE;
            HREADY_OUT <= 1'b1;
            HRESP      <= 1'b0;
            HRDATA     <= '0;
            PSEL       <= '0;
            PENABLE    <= 1'b0;
            PADDR      <= '0;
            PWRITE     <= 1'b0;
            PWDATA     <= '0;
            idx_q      <= '0;
            cnt        <= '0;
        end else begin
            state      <= state_n;
            HREADY_OUT <= state_n inside {IDLE, ERR2};
            HRESP      <= state_n inside {ERR1, ERR2};
            PSEL       <= state_n inside {SETUP, ACCESS} ? NUM_SLAVES'(1) << idx_n : '0;
            PENABLE    <= state_n == ACCESS;
            cnt        <= state_n == SETUP ? '0 : (state == ACCESS && !sel_ready) ? cnt_n : cnt;
            if (accept) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
                idx_q  <= idx_in;
            end
            if (state == WLATCH)
                PWDATA <= HWDATA;
            if (state == ACCESS && sel_ready && !sel_err && !PWRITE)
                HRDATA <= PRDATA[idx_q*DATA_WIDTH +: DATA_WIDTH];
        end
    end
endmodule
